// File: rtl/viterbi_pkg.sv
// rtl/viterbi_pkg.sv - shared constants and types for the Viterbi traceback slice
package viterbi_pkg;

    localparam int STATES = 4;
    localparam int SW     = 2;
    localparam int DEPTH  = 16;
    localparam int AW     = 4;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        TRACE,
        EMIT,
        FIN,
        HOLD
    } tb_state_t;

    typedef logic [STATES-1:0] dec_vec_t;

endpackage

// File: rtl/survivor_mem.sv
// rtl/survivor_mem.sv - DEPTH x STATES survivor decision register file
module survivor_mem #(
    parameter int STATES = 4,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [STATES-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [STATES-1:0] rdata
);

    // Contents are don't-care after reset, so the array carries no reset.
    logic [STATES-1:0] mem [DEPTH];

    // Synchronous write of one decision vector per stored stage.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/viterbi_traceback.sv
// rtl/viterbi_traceback.sv - survivor store, traceback walk and oldest-first bit emission
module viterbi_traceback #(
    parameter int STATES = 4,
    parameter int SW     = 2,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_mem,
    input  logic              en_tbck,
    input  logic [STATES-1:0] dec_in,
    input  logic [SW-1:0]     best_state,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              overflow
);
    import viterbi_pkg::*;

    // wp and len need one extra bit so that a full memory (DEPTH) is representable.
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    tb_state_t         state;
    tb_state_t         nxt;
    logic [AW:0]       wp;
    logic [AW:0]       len;
    logic [AW-1:0]     rp;
    logic [AW-1:0]     idx;
    logic [SW-1:0]     cur;
    logic [DEPTH-1:0]  obuf;
    logic [STATES-1:0] rd_vec;
    logic              start;
    logic              store;
    logic              drop;
    logic              accept;

    // en_tbck wins over en_mem, so the start cycle never writes.
    assign start  = ((state == IDLE) || (state == FILL)) && en_tbck;
    assign store  = en_mem && !en_tbck && ((state == IDLE) || ((state == FILL) && (wp != FULL)));
    assign drop   = en_mem && !en_tbck && (state == FILL) && (wp == FULL);
    assign accept = (state == EMIT) && out_ready;

    assign out_bit = obuf[rp];

    survivor_mem #(
        .STATES(STATES),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk  (clk),
        .we   (store),
        .waddr(wp[AW-1:0]),
        .wdata(dec_in),
        .raddr(idx),
        .rdata(rd_vec)
    );

    // Next-state selection for the frame sequencer.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (en_tbck)     nxt = FIN;
                else if (en_mem) nxt = FILL;
            end
            FILL: begin
                if (en_tbck) nxt = (wp == '0) ? FIN : TRACE;
            end
            TRACE: begin
                if (idx == '0) nxt = EMIT;
            end
            EMIT: begin
                if (out_ready && (rp == AW'(len - 1'b1))) nxt = FIN;
            end
            FIN:     nxt = HOLD;
            HOLD: begin
                if (!en_tbck) nxt = IDLE;
            end
            default: nxt = IDLE;
        endcase
    end

    // State register plus registered status outputs decoded from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= nxt;
            out_valid <= (nxt == EMIT);
            busy      <= (nxt == TRACE) || (nxt == EMIT);
            done      <= (nxt == FIN);
        end
    end

    // Write pointer, traceback walk, output buffer and read pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp       <= '0;
            len      <= '0;
            rp       <= '0;
            idx      <= '0;
            cur      <= '0;
            obuf     <= '0;
            overflow <= 1'b0;
        end else begin
            if (store) wp <= wp + 1'b1;
            if (drop)  overflow <= 1'b1;
            if (start) begin
                cur <= best_state;
                len <= wp;
                idx <= AW'(wp - 1'b1);
            end
            if (state == TRACE) begin
                // The state's MSB is the input bit that led into it; the decision
                // bit selects which predecessor feeds the LSB on the way back.
                obuf[idx] <= cur[SW-1];
                cur       <= {cur[SW-2:0], rd_vec[cur]};
                if (idx == '0) rp  <= '0;
                else           idx <= idx - 1'b1;
            end
            if (accept) rp <= rp + 1'b1;
            if (state == FIN) begin
                wp  <= '0;
                len <= '0;
            end
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// tb/tb_viterbi_traceback.sv - randomized self-checking bench for viterbi_traceback
module tb_viterbi_traceback;

    logic       clk = 1'b0;
    logic       rst;
    logic       en_mem;
    logic       en_tbck;
    logic [3:0] dec_in;
    logic [1:0] best_state;
    logic       out_bit;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;
    logic       overflow;

    int         checks   = 0;
    int         failures = 0;
    logic [3:0] dec_arr [32];
    logic       exp_bits [16];
    logic       ovf_model;
    logic [6:0] bp_pat;

    always #5 clk = ~clk;

    viterbi_traceback #(
        .STATES(4),
        .SW    (2),
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en_mem    (en_mem),
        .en_tbck   (en_tbck),
        .dec_in    (dec_in),
        .best_state(best_state),
        .out_bit   (out_bit),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Reference decoder: walk the trellis backwards with integer state arithmetic.
    function automatic void ref_decode(input int n, input int best);
        int st;
        int len;
        st  = best;
        len = (n > 16) ? 16 : n;
        for (int s = len - 1; s >= 0; s--) begin
            exp_bits[s] = (st >= 2);
            st = ((st * 2) % 4) + int'(dec_arr[s][st]);
        end
    endfunction

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) dec_arr[i] = 4'($urandom);
    endtask

    task automatic store_frame(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check("overflow_fill", overflow, ovf_model);
            en_mem  = 1'b1;
            en_tbck = 1'b0;
            dec_in  = dec_arr[i];
            if (i >= 16) ovf_model = 1'b1;
        end
    endtask

    // mode 0: ready tied high, 1: fixed backpressure pattern, 2: random ready.
    task automatic traceback(input int n, input int best, input int mode);
        int   len;
        int   k;
        int   acc;
        int   first;
        int   last_acc;
        int   p;
        bit   got_done;
        logic r;
        len = (n > 16) ? 16 : n;
        k = 0; acc = 0; first = -1; last_acc = -1; p = 0; got_done = 1'b0;
        @(negedge clk);
        check("overflow_start", overflow, ovf_model);
        en_mem     = 1'b1;
        en_tbck    = 1'b1;
        best_state = 2'(best);
        dec_in     = 4'($urandom);
        out_ready  = (mode == 0);
        while (!got_done && k < 100) begin
            @(negedge clk);
            k++;
            if (k == 1) check("busy_after_start", busy, len > 0);
            if (out_valid) begin
                if (first < 0) first = k;
                check("accept_bound", acc < len, 1);
                if (acc < len) check("out_bit", out_bit, exp_bits[acc]);
                if (mode == 0)      r = 1'b1;
                else if (mode == 1) r = bp_pat[p % 7];
                else                r = 1'($urandom_range(0, 1));
                p++;
                out_ready = r;
                if (r) begin
                    acc++;
                    last_acc = k;
                end
            end else begin
                if (done) got_done = 1'b1;
                out_ready = (mode == 0);
            end
            en_mem = 1'($urandom_range(0, 1));
            dec_in = 4'($urandom);
        end
        check("done_seen", got_done, 1);
        check("accepts", acc, len);
        if (len > 0) begin
            check("first_valid_cycle", first, len + 1);
            check("done_cycle", k, last_acc + 1);
        end else begin
            check("done_cycle_len0", k, 1);
        end
        check("busy_at_done", busy, 0);
        for (int h = 0; h < 3; h++) begin
            @(negedge clk);
            check("hold_quiet", {done, busy, out_valid}, 0);
            en_mem = 1'b1;
        end
        @(negedge clk);
        en_tbck   = 1'b0;
        en_mem    = 1'b0;
        out_ready = 1'b0;
    endtask

    initial begin
        int   b;
        int   n;
        bit   seen;
        rst        = 1'b1;
        en_mem     = 1'b0;
        en_tbck    = 1'b0;
        dec_in     = '0;
        best_state = '0;
        out_ready  = 1'b0;
        ovf_model  = 1'b0;
        bp_pat     = 7'b1110100;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_overflow", overflow, 0);
        check("rst_out_bit", out_bit, 0);
        rst = 1'b0;

        // Zero decisions, best state 2'b10.
        for (int i = 0; i < 4; i++) dec_arr[i] = 4'b0000;
        exp_bits[0] = 0; exp_bits[1] = 0; exp_bits[2] = 0; exp_bits[3] = 1;
        store_frame(4);
        traceback(4, 2, 0);

        // All-ones decisions, best state 2'b00.
        for (int i = 0; i < 4; i++) dec_arr[i] = 4'b1111;
        exp_bits[0] = 1; exp_bits[1] = 1; exp_bits[2] = 0; exp_bits[3] = 0;
        store_frame(4);
        traceback(4, 0, 0);

        // Backpressure on the zero-decision frame.
        for (int i = 0; i < 4; i++) dec_arr[i] = 4'b0000;
        exp_bits[0] = 0; exp_bits[1] = 0; exp_bits[2] = 0; exp_bits[3] = 1;
        store_frame(4);
        traceback(4, 2, 1);

        // Empty frame: traceback straight from IDLE.
        traceback(0, int'($urandom_range(0, 3)), 0);

        // Three stores, start with en_mem still high.
        fill_random(3);
        b = int'($urandom_range(0, 3));
        ref_decode(3, b);
        store_frame(3);
        traceback(3, b, 2);

        // Random frames up to full depth.
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(1, 16));
            fill_random(n);
            b = int'($urandom_range(0, 3));
            ref_decode(n, b);
            store_frame(n);
            traceback(n, b, (f % 2 == 0) ? 2 : 0);
        end

        // Reset in the middle of emission.
        fill_random(4);
        store_frame(4);
        @(negedge clk);
        en_mem     = 1'b0;
        en_tbck    = 1'b1;
        best_state = 2'($urandom);
        out_ready  = 1'b1;
        seen       = 1'b0;
        for (int w = 0; w < 30 && !seen; w++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        check("mid_emit_valid_seen", seen, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_out_valid", out_valid, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        @(negedge clk);
        rst       = 1'b0;
        en_tbck   = 1'b0;
        out_ready = 1'b0;
        fill_random(4);
        b = int'($urandom_range(0, 3));
        ref_decode(4, b);
        store_frame(4);
        traceback(4, b, 0);

        // Overflow: 18 stores into a 16-deep memory.
        fill_random(18);
        b = int'($urandom_range(0, 3));
        ref_decode(18, b);
        store_frame(18);
        traceback(18, b, 2);

        // Overflow stays set across the next frame.
        fill_random(2);
        b = int'($urandom_range(0, 3));
        ref_decode(2, b);
        store_frame(2);
        traceback(2, b, 0);

        @(negedge clk);
        rst = 1'b1;
        ovf_model = 1'b0;
        @(negedge clk);
        check("overflow_cleared", overflow, 0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/viterbi_traceback.md
# viterbi_traceback

Traceback stage of the Viterbi decoder, directly downstream of the ACS and stage controller. It stores one survivor-decision vector per trellis stage while `en_mem` is high and `en_tbck` is low. When `en_tbck` rises, it walks the survivor memory backwards from the best end state, one stage per cycle, and rebuilds the decoded bits. It then streams the decoded bits out oldest-first on a valid/ready handshake.

## Interface
Parameters:
- `STATES`, default 4: number of trellis states (K=3 code).
- `SW`, default 2: state width, log2(STATES).
- `DEPTH`, default 16: survivor memory stages; this is the maximum frame length.
- `AW`, default 4: address width, log2(DEPTH).

Ports (clock and reset first):
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `en_mem`, in, 1: store enable, from the controller.
- `en_tbck`, in, 1: traceback enable, from the controller. It stays high until the frame ends.
- `dec_in`, in, STATES: ACS decision bit per state. Bit i is the survivor choice into state i.
- `best_state`, in, SW: state with the minimum path metric. Sampled on the traceback start cycle.
- `out_bit`, out, 1: decoded bit.
- `out_valid`, out, 1: `out_bit` is valid.
- `out_ready`, in, 1: consumer accepts `out_bit`.
- `busy`, out, 1: high in TRACE and EMIT.
- `done`, out, 1: one-cycle pulse after the last bit is accepted.
- `overflow`, out, 1: sticky flag; a store was attempted with the memory full.

## Operation
State machine states: IDLE, FILL, TRACE, EMIT, FIN, HOLD.

- **Reset:** state=IDLE. `wp`, `rp`, `len`, `cur` = 0. All outputs 0. Memory contents are don't-care.
- **IDLE:**
  - `en_mem`=1 and `en_tbck`=0: write `mem[0]`=`dec_in`, set `wp`=1, go to FILL.
  - `en_tbck`=1: start traceback with `len`=0.
- **FILL:**
  - `en_mem`=1 and `en_tbck`=0 and `wp`<DEPTH: write `mem[wp]`, then `wp`++.
  - `wp`==DEPTH: the write is dropped and `overflow` is set. `overflow` clears only on reset.
- **Traceback start:** the first cycle with `en_tbck`=1 in IDLE or FILL.
  - Latch `cur`=`best_state` and `len`=`wp`. The write is suppressed even if `en_mem`=1, because `en_tbck` has priority.
  - `len`==0: go to FIN. Otherwise set `idx`=`len`-1 and go to TRACE.
- **TRACE:** one stage per cycle.
  - `d`=`mem[idx][cur]`.
  - `obuf[idx]`=`cur[SW-1]`.
  - `cur`={`cur[SW-2:0]`, `d`}.
  - After `idx`==0 is processed, set `rp`=0 and go to EMIT.
- **EMIT:**
  - `out_valid`=1 and `out_bit`=`obuf[rp]`.
  - On `out_valid`&&`out_ready`, `rp`++.
  - When `rp`==`len`-1 is accepted, go to FIN.
  - `out_bit` is held stable while `out_valid`=1 and `out_ready`=0.
- **FIN:** `done`=1 for one cycle. Clear `wp` and `len`. Go to HOLD.
- **HOLD:** wait for `en_tbck`=0, then go to IDLE. This is needed because the controller holds traceback asserted. `en_mem` is ignored in HOLD.
- **Inputs outside FILL/IDLE:** `en_tbck` deasserting during TRACE or EMIT is ignored. `dec_in` and `en_mem` are ignored.
- **Reset mid-operation:** return to IDLE immediately. Any partial frame is discarded.

## Timing
- Store: `dec_in` is written on the same edge where `en_mem` is sampled.
- Traceback latency: `len` cycles from the start edge to the EMIT entry edge.
- First `out_valid`: high in the cycle after the last TRACE cycle. That is `len`+1 cycles after the start edge.
- Emission throughput: 1 bit/cycle with `out_ready` tied high.
- `done`: asserts exactly one cycle after the accepting edge of the last bit. For `len`=0, it asserts one cycle after start.
- Outputs: all outputs are registered, except `out_bit`, which is a mux of registered `obuf`/`rp`.

## Structure
- **Shared package `viterbi_pkg`:**
  - Constants: STATES, SW, DEPTH, AW.
  - Typedef `tb_state_t`: the enum IDLE/FILL/TRACE/EMIT/FIN/HOLD.
  - Typedef `dec_vec_t`: logic [STATES-1:0].
- **Sub-module `survivor_mem`:** DEPTH×STATES register file.
  - One synchronous write port.
  - One combinational read port, addressed by `idx`.
- **Kept in the top level:** `obuf` (DEPTH×1) and the state machine.

## Test plan
- **Zero decisions, best state 2'b10:** reset, then 4 stores of `dec_in`=4'b0000, then `en_tbck`=1 with `best_state`=2'b10, `out_ready`=1. Required: stream 0,0,0,1 (oldest first), then `done` pulse, `overflow`=0.
- **All-ones decisions, best state 2'b00:** 4 stores of `dec_in`=4'b1111, `best_state`=2'b00. Required: stream 1,1,0,0. First `out_valid` 5 cycles after the start edge.
- **Backpressure:** same frame as the first scenario, with `out_ready` toggled 0,0,1,0,1,1,1. Required: each bit is held stable while not accepted. Exactly 4 accepts occur, and the order 0,0,0,1 is preserved.
- **Overflow:** 18 store cycles with DEPTH=16. Required: `overflow`=1 from the 17th cycle on. `len`=16 and 16 bits are emitted.
- **Traceback priority:** `en_mem`=1 and `en_tbck`=1 in the same cycle after 3 stores. Required: no 4th write, `len`=3, 3 bits emitted. Afterwards the block stays in HOLD until `en_tbck`=0.
- **Reset mid-EMIT:** `rst` pulse during EMIT of a 4-bit frame. Required: `out_valid`, `busy`, `done` = 0 immediately. The next frame decodes correctly from `wp`=0.
